// File: rtl/aes_sbox_pkg.sv
// Shared constants, field arithmetic and mode type for the pipelined AES S-box.
// Tower field: GF(((2^2)^2)^2), GF(2^2) mod x^2+x+1, phi=2, lambda=0xC.
package aes_sbox_pkg;

   localparam int SBOX_LATENCY = 6;

   // Row r of each matrix is byte r (row 7 in the top byte).
   localparam logic [63:0] AFF_FWD   = 64'hF87C3E1F8FC7E3F1;
   localparam logic [63:0] AFF_INV   = 64'h5229944A259249A4;
   localparam logic [7:0]  AFF_FWD_C = 8'h63;
   localparam logic [7:0]  AFF_INV_C = 8'h05;
   localparam logic [63:0] ISO_FWD   = 64'hA0DEACAEC69E5243;
   localparam logic [63:0] ISO_INV   = 64'hE24462763E9E3075;
   localparam logic [3:0]  GF4_LAMBDA = 4'hC;

   typedef enum logic {
      SBOX_FWD = 1'b0,
      SBOX_INV = 1'b1
   } sbox_mode_e;

   function automatic logic [7:0] mat8(
      input logic [63:0] m,
      input logic [7:0]  x
   );
      logic [7:0] y;
      for (int r = 0; r < 8; r++)
         y[r] = ^(m[8*r +: 8] & x);
      return y;
   endfunction

   function automatic logic [1:0] gf2_mul(
      input logic [1:0] a,
      input logic [1:0] b
   );
      logic m;
      m = a[0] & b[0];
      return {((a[1] ^ a[0]) & (b[1] ^ b[0])) ^ m,
              (a[1] & b[1]) ^ m};
   endfunction

   function automatic logic [1:0] gf2_sq(input logic [1:0] a);
      return {a[1], a[1] ^ a[0]};
   endfunction

   function automatic logic [1:0] gf2_phi(input logic [1:0] a);
      return {a[1] ^ a[0], a[1]};
   endfunction

   function automatic logic [3:0] gf4_mul(
      input logic [3:0] k,
      input logic [3:0] w
   );
      logic [1:0] hh, ll, mm;
      hh = gf2_mul(k[3:2], w[3:2]);
      ll = gf2_mul(k[1:0], w[1:0]);
      mm = gf2_mul(k[3:2] ^ k[1:0], w[3:2] ^ w[1:0]);
      return {mm ^ ll, gf2_phi(hh) ^ ll};
   endfunction

   function automatic logic [3:0] gf4_sq_scl(input logic [3:0] h);
      return gf4_mul(gf4_mul(h, h), GF4_LAMBDA);
   endfunction

   function automatic logic [3:0] gf4_inv(input logic [3:0] k);
      logic [1:0] h, l, d, di;
      h  = k[3:2];
      l  = k[1:0];
      d  = gf2_phi(gf2_sq(h)) ^ gf2_mul(h, l) ^ gf2_sq(l);
      di = gf2_sq(d);
      return {gf2_mul(h, di), gf2_mul(h ^ l, di)};
   endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One byte lane: six enabled stages of composite-field S-box.
// AES_SBOX_STAGE_TAP_EN exposes the six stage data registers on tap.
module aes_sbox_lane
   import aes_sbox_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] in_data,
   input  sbox_mode_e in_mode,
   input  sbox_mode_e s5_mode,
   output logic [7:0] out_data
`ifdef AES_SBOX_STAGE_TAP_EN
   ,
   output logic [8*SBOX_LATENCY-1:0] tap
`endif
);

   logic [7:0] pre;
   logic [7:0] s1, s2, s3, s4, s5, s6;
   logic [3:0] d2, i3;

   // inverse beats undo the affine map before field inversion
   always_comb begin
      pre = in_data;
      if (in_mode == SBOX_INV)
         pre = mat8(AFF_INV, in_data) ^ AFF_INV_C;
   end

   // map, norm, norm inverse, product, unmap, affine
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
         s4 <= '0;
         s5 <= '0;
         s6 <= '0;
         d2 <= '0;
         i3 <= '0;
      end else if (en) begin
         s1 <= mat8(ISO_FWD, pre);
         s2 <= s1;
         d2 <= gf4_sq_scl(s1[7:4])
             ^ gf4_mul(s1[7:4], s1[3:0])
             ^ gf4_mul(s1[3:0], s1[3:0]);
         s3 <= s2;
         i3 <= gf4_inv(d2);
         s4 <= {gf4_mul(s3[7:4], i3),
                gf4_mul(s3[7:4] ^ s3[3:0], i3)};
         s5 <= mat8(ISO_INV, s4);
         s6 <= (s5_mode == SBOX_FWD)
             ? (mat8(AFF_FWD, s5) ^ AFF_FWD_C)
             : s5;
      end
   end

   assign out_data = s6;

`ifdef AES_SBOX_STAGE_TAP_EN
   assign tap = {s6, s5, s4, s3, s2, s1};
`endif

endmodule

// File: rtl/aes_sbox_pipe_array.sv
// Multi-lane 6-stage AES S-box with valid/ready, tag, flush, inflight count.
// AES_SBOX_STAGE_TAP_EN adds the stage_tap debug port.
module aes_sbox_pipe_array
   import aes_sbox_pkg::*;
#(
   parameter int LANES   = 2,
   parameter int TAG_W   = 4,
   parameter int LATENCY = 6
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_inv,
   input  logic [8*LANES-1:0]           in_data,
   input  logic [TAG_W-1:0]             in_tag,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [8*LANES-1:0]           out_data,
   output logic [TAG_W-1:0]             out_tag,
   output logic [$clog2(LATENCY+1)-1:0] inflight
`ifdef AES_SBOX_STAGE_TAP_EN
   ,
   output logic [LATENCY*8*LANES-1:0]   stage_tap
`endif
);

   localparam int DW = 8 * LANES;
   localparam int CW = $clog2(LATENCY + 1);

   if (LATENCY != SBOX_LATENCY) begin : g_bad_lat
      $error("aes_sbox_pipe_array: LATENCY must be 6");
   end
   if (TAG_W < 1) begin : g_bad_tag
      $error("aes_sbox_pipe_array: TAG_W must be >= 1");
   end

   logic              advance;
   logic              accept;
   logic              drain;
   sbox_mode_e        mode_in;
   logic [LATENCY-1:0] vld;
   logic [TAG_W-1:0]  tag_q  [LATENCY];
   sbox_mode_e        mode_q [LATENCY-1];

   assign out_valid = vld[LATENCY-1];
   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance && !flush;
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;
   assign mode_in   = sbox_mode_e'(in_inv);
   assign out_tag   = tag_q[LATENCY-1];

   // valid chain; bubbles enter whenever nothing is accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         vld <= '0;
      else if (flush)
         vld <= '0;
      else if (advance)
         vld <= {vld[LATENCY-2:0], accept};
   end

   // tag and mode ride alongside the lane data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < LATENCY; k++)
            tag_q[k] <= '0;
         for (int k = 0; k < LATENCY-1; k++)
            mode_q[k] <= SBOX_FWD;
      end else if (advance) begin
         tag_q[0]  <= in_tag;
         mode_q[0] <= mode_in;
         for (int k = 1; k < LATENCY; k++)
            tag_q[k] <= tag_q[k-1];
         for (int k = 1; k < LATENCY-1; k++)
            mode_q[k] <= mode_q[k-1];
      end
   end

   // beats held: accepts minus drains, cleared by flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         inflight <= '0;
      else if (flush)
         inflight <= '0;
      else
         inflight <= inflight + CW'(accept) - CW'(drain);
   end

`ifdef AES_SBOX_STAGE_TAP_EN
   logic [8*SBOX_LATENCY-1:0] lane_tap [LANES];

   // regroup per-lane taps into per-stage slices
   always_comb begin
      stage_tap = '0;
      for (int k = 0; k < LATENCY; k++)
         for (int i = 0; i < LANES; i++)
            stage_tap[k*DW + 8*i +: 8] = lane_tap[i][8*k +: 8];
   end
`endif

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      aes_sbox_lane u_lane (
         .clk      (clk),
         .rst      (rst),
         .en       (advance),
         .in_data  (in_data[8*i +: 8]),
         .in_mode  (mode_in),
         .s5_mode  (mode_q[LATENCY-2]),
         .out_data (out_data[8*i +: 8])
`ifdef AES_SBOX_STAGE_TAP_EN
         ,
         .tap      (lane_tap[i])
`endif
      );
   end

endmodule

// File: tb/tb_aes_sbox_pipe_array.sv
// Bench for aes_sbox_pipe_array: directed cases plus random stream,
// checked by a reference GF(2^8) model and an expected-result queue.
module tb_aes_sbox_pipe_array;

   localparam int LANES = 2;
   localparam int TAG_W = 4;
   localparam int LAT   = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic        in_inv;
   logic [15:0] in_data;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [3:0]  out_tag;
   logic [2:0]  inflight;
`ifdef AES_SBOX_STAGE_TAP_EN
   logic [LAT*16-1:0] tap;
`endif

   int total = 0;
   int bad   = 0;
   bit done  = 0;

   typedef struct packed {
      logic [15:0] d;
      logic [3:0]  t;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   aes_sbox_pipe_array #(
      .LANES(LANES), .TAG_W(TAG_W), .LATENCY(LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_inv    (in_inv),
      .in_data   (in_data),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .inflight  (inflight)
`ifdef AES_SBOX_STAGE_TAP_EN
      ,
      .stage_tap (tap)
`endif
   );

   task automatic chk(
      input string       nm,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(
      input logic [7:0] a,
      input logic [7:0] b
   );
      logic [7:0] p = 8'h00;
      logic       hi;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         hi = a[7];
         a  = a << 1;
         if (hi) a ^= 8'h1B;
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] x);
      logic [7:0] c;
      if (x == 8'h00) return 8'h00;
      for (int i = 1; i < 256; i++) begin
         c = 8'(i);
         if (gmul(x, c) == 8'h01) return c;
      end
      return 8'h00;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
      logic [15:0] t;
      t = {x, x};
      return t[15-k -: 8];
   endfunction

   function automatic logic [7:0] ref8(input logic [7:0] x, input logic inv);
      logic [7:0] y;
      if (!inv) begin
         y = ginv(x);
         return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
      end
      y = rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
      return ginv(y);
   endfunction

   function automatic logic [15:0] ref16(input logic [15:0] x, input logic inv);
      return {ref8(x[15:8], inv), ref8(x[7:0], inv)};
   endfunction

   // scoreboard: drain checks first, then record the beat being accepted
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_extra", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               chk("sb_data", out_data, mon_e.d);
               chk("sb_tag", out_tag, mon_e.t);
            end
         end
         if (flush)
            sb.delete();
         else if (in_valid && in_ready)
            sb.push_back('{d: ref16(in_data, in_inv), t: in_tag});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(
      input logic [15:0] d,
      input logic        inv,
      input logic [3:0]  t
   );
      bit ok = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_inv   = inv;
      in_tag   = t;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      chk("send_accept", 32'(ok), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_out(
      input  logic [15:0] d,
      input  logic [3:0]  t,
      output int          w
   );
      w = 0;
      @(negedge clk);
      while (!out_valid && w < 50) begin
         w++;
         @(negedge clk);
      end
      chk("out_valid", 32'(out_valid), 1);
      chk("out_data", out_data, d);
      chk("out_tag", out_tag, t);
      @(posedge clk);
      #1;
   endtask

   task automatic lat_run(
      input logic [15:0] d,
      input logic [15:0] exp,
      input string       nm
   );
      int k;
      send(d, 1'b0, 4'h0);
      k = 1;
      @(negedge clk);
      chk({nm, "_infl1"}, inflight, 1);
      while (!out_valid && k < 20) begin
         @(posedge clk);
         k++;
         @(negedge clk);
      end
      chk({nm, "_lat"}, k, 6);
      chk({nm, "_data"}, out_data, exp);
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_infl0"}, inflight, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog total=%0d", total);
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] hd [6];
      logic [15:0] held;
      int w;

      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_inv    = 1'b0;
      in_data   = '0;
      in_tag    = '0;
      out_ready = 1'b1;

      #23;
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_inflight", inflight, 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      tick();

      lat_run(16'hA55A, 16'h06BE, "single");

      send(16'h0000, 1'b0, 4'd1);
      send(16'h5353, 1'b0, 4'd2);
      send(16'hFFFF, 1'b0, 4'd3);
      expect_out(16'h6363, 4'd1, w);
      expect_out(16'hEDED, 4'd2, w);
      chk("b2b_gap1", w, 0);
      expect_out(16'h1616, 4'd3, w);
      chk("b2b_gap2", w, 0);

      send(16'h63ED, 1'b1, 4'd5);
      expect_out(16'h0053, 4'd5, w);
      send(16'h0101, 1'b0, 4'd6);
      send(16'h7C7C, 1'b1, 4'd7);
      expect_out(16'h7C7C, 4'd6, w);
      expect_out(16'h0101, 4'd7, w);
      chk("mix_gap", w, 0);

      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         hd[i] = 16'(i * 16'h3725 + 16'h1B09);
         send(hd[i], i[0], 4'(i + 8));
      end
      @(negedge clk);
      held = out_data;
      chk("full_valid", 32'(out_valid), 1);
      for (int i = 0; i < 4; i++) begin
         chk("stall_in_ready", 32'(in_ready), 0);
         chk("stall_data", out_data, held);
         chk("stall_infl", inflight, 6);
         @(posedge clk);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         expect_out(ref16(hd[i], i[0]), 4'(i + 8), w);
         chk("drain_gap", w, 0);
      end

      send(16'h1111, 1'b0, 4'd1);
      send(16'h2222, 1'b0, 4'd2);
      send(16'h3333, 1'b0, 4'd3);
      in_valid = 1'b1;
      in_data  = 16'hC3A0;
      in_inv   = 1'b0;
      in_tag   = 4'd9;
      flush    = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_infl", inflight, 0);
      chk("flush_valid", 32'(out_valid), 0);
      chk("flush_retry_rdy", 32'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      expect_out(ref16(16'hC3A0, 1'b0), 4'd9, w);
      chk("flush_retry_lat", w, 5);

      for (int i = 0; i < 4; i++)
         send(16'(16'h0F1E * (i + 1)), 1'b0, 4'(i));
      repeat (3) tick();
      chk("rst_pre_valid", 32'(out_valid), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 0);
      chk("arst_data", out_data, 0);
      chk("arst_infl", inflight, 0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_in_ready", 32'(in_ready), 1);
      @(posedge clk);
      #1;
      lat_run(16'hFFFF, 16'h1616, "post_rst");

      fork
         begin
            for (int i = 0; i < 150; i++) begin
               if ($urandom_range(0, 3) == 0) tick();
               send(16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom));
            end
            done = 1;
         end
         begin
            while (!done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               tick();
            end
            out_ready = 1'b1;
         end
      join
      for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
      chk("sb_empty", sb.size(), 0);
      chk("end_infl", inflight, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
